// File: rtl/gcd_job_driver.sv
// ---------------------------------------------------------------------------
// gcd_job_driver
//
// Request-side controller for the repeated-subtraction GCD calculator.
// It takes one operand pair per job, restarts the calculator, loads A and
// then B on their one-cycle strobes, and waits for calc_out_ready. It then
// returns the GCD, an error flag and the number of WAIT cycles used.
// Zero operands are answered locally, because the calculator never
// terminates on them. A watchdog aborts any job that waits too long.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles allowed before the job is aborted (>= 2)
//   CLR_CYCLES      cycles calc_rst is held high before loading (>= 1)
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   job_valid/job_ready      job handshake; job_a, job_b are the operands
//   calc_rst                 active-high restart to the calculator
//   calc_a, calc_b           operands to the calculator (hold last load)
//   calc_a/b_available       one-cycle load strobes
//   calc_out, calc_out_ready calculator result and its sticky valid level
//   res_valid/res_ready      result handshake
//   res_gcd, res_err         GCD (0 on error), timeout flag
//   res_cycles               WAIT cycles spent, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module gcd_job_driver #(
    parameter int TIMEOUT_CYCLES = 600,
    parameter int CLR_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [7:0]  job_a,
    input  logic [7:0]  job_b,
    output logic        calc_rst,
    output logic [7:0]  calc_a,
    output logic [7:0]  calc_b,
    output logic        calc_a_available,
    output logic        calc_b_available,
    input  logic [7:0]  calc_out,
    input  logic        calc_out_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_gcd,
    output logic        res_err,
    output logic [15:0] res_cycles
);

    localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CCW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD_A,
        LOAD_B,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [7:0]     op_a;
    logic [7:0]     op_b;
    logic [7:0]     calc_a_q;
    logic [7:0]     calc_b_q;
    logic [CCW-1:0] clr_cnt;
    logic [WCW-1:0] wait_cnt;
    logic [WCW-1:0] wait_nxt;
    logic [31:0]    wait_wide;
    logic [15:0]    cycles_sat;
    logic           clr_done;
    logic           wait_hit;
    logic           accept;
    logic           zero_job;

    assign clr_done   = (clr_cnt == CCW'(CLR_CYCLES - 1));
    assign wait_nxt   = wait_cnt + WCW'(1);
    assign wait_hit   = (wait_nxt == WCW'(TIMEOUT_CYCLES));
    assign wait_wide  = 32'(wait_nxt);
    assign cycles_sat = (wait_wide > 32'h0000_FFFF) ? 16'hFFFF : wait_wide[15:0];
    assign accept     = (state == IDLE) && job_valid;
    assign zero_job   = (job_a == 8'd0) || (job_b == 8'd0);

    // The operand buses show the latched operand during their load cycle and
    // keep the last loaded value everywhere else.
    assign calc_a = (state == LOAD_A) ? op_a : calc_a_q;
    assign calc_b = (state == LOAD_B) ? op_b : calc_b_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        job_ready        = 1'b0;
        calc_rst         = 1'b1;
        calc_a_available = 1'b0;
        calc_b_available = 1'b0;
        res_valid        = 1'b0;
        case (state)
            IDLE: begin
                // Gated with rst so job_ready is low for the whole reset.
                job_ready = rst;
                if (job_valid && rst) begin
                    state_nxt = zero_job ? RESP : CLR;
                end
            end
            CLR: begin
                if (clr_done) begin
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A: begin
                calc_rst         = 1'b0;
                calc_a_available = 1'b1;
                state_nxt        = LOAD_B;
            end
            LOAD_B: begin
                calc_rst         = 1'b0;
                calc_b_available = 1'b1;
                state_nxt        = WAIT;
            end
            WAIT: begin
                calc_rst = 1'b0;
                if (calc_out_ready || wait_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a       <= '0;
            op_b       <= '0;
            calc_a_q   <= '0;
            calc_b_q   <= '0;
            clr_cnt    <= '0;
            wait_cnt   <= '0;
            res_gcd    <= '0;
            res_err    <= 1'b0;
            res_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= job_a;
                        op_b    <= job_b;
                        clr_cnt <= '0;
                        if (zero_job) begin
                            // gcd(x,0)=x and gcd(0,0)=0, so OR gives the answer.
                            res_gcd    <= job_a | job_b;
                            res_err    <= 1'b0;
                            res_cycles <= '0;
                        end
                    end
                end
                CLR: begin
                    clr_cnt <= clr_cnt + CCW'(1);
                end
                LOAD_A: begin
                    calc_a_q <= op_a;
                end
                LOAD_B: begin
                    calc_b_q <= op_b;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_nxt;
                    // The calculator result takes priority over the watchdog.
                    if (calc_out_ready) begin
                        res_gcd    <= calc_out;
                        res_err    <= 1'b0;
                        res_cycles <= cycles_sat;
                    end else if (wait_hit) begin
                        res_gcd    <= '0;
                        res_err    <= 1'b1;
                        res_cycles <= cycles_sat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_driver.sv
module tb_gcd_job_driver;

    localparam int TO   = 16;
    localparam int CLRC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [7:0]  job_a = 8'd0;
    logic [7:0]  job_b = 8'd0;
    logic        calc_rst;
    logic [7:0]  calc_a;
    logic [7:0]  calc_b;
    logic        calc_a_available;
    logic        calc_b_available;
    logic [7:0]  calc_out;
    logic        calc_out_ready;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_gcd;
    logic        res_err;
    logic [15:0] res_cycles;

    int unsigned vectors = 0;
    int unsigned miss    = 0;

    always #5 clk = ~clk;

    gcd_job_driver #(
        .TIMEOUT_CYCLES(TO),
        .CLR_CYCLES    (CLRC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_a            (job_a),
        .job_b            (job_b),
        .calc_rst         (calc_rst),
        .calc_a           (calc_a),
        .calc_b           (calc_b),
        .calc_a_available (calc_a_available),
        .calc_b_available (calc_b_available),
        .calc_out         (calc_out),
        .calc_out_ready   (calc_out_ready),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_gcd          (res_gcd),
        .res_err          (res_err),
        .res_cycles       (res_cycles)
    );

    // Behavioural calculator: result becomes visible m_lat cycles after the
    // B strobe (first WAIT cycle counts as 1), or never when m_hang is set.
    logic [7:0]  m_a    = 8'd0;
    logic [7:0]  m_g    = 8'd0;
    logic        m_busy = 1'b0;
    int unsigned m_cnt  = 0;
    int unsigned m_lat  = 1;
    logic        m_hang = 1'b0;

    function automatic logic [7:0] gcd_ref(input logic [7:0] x0, input logic [7:0] y0);
        logic [7:0] x, y, t;
        x = x0;
        y = y0;
        while (y != 8'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (calc_rst) begin
            m_busy <= 1'b0;
        end else if (calc_a_available) begin
            m_a <= calc_a;
        end else if (calc_b_available) begin
            m_g    <= gcd_ref(m_a, calc_b);
            m_busy <= !m_hang;
            m_cnt  <= m_lat - 1;
        end else if (m_busy && m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign calc_out_ready = m_busy && (m_cnt == 0);
    assign calc_out       = calc_out_ready ? m_g : 8'hA5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_job_ready"},  32'(job_ready), 0);
        check({tag, "_calc_rst"},   32'(calc_rst), 1);
        check({tag, "_calc_a"},     32'(calc_a), 0);
        check({tag, "_calc_b"},     32'(calc_b), 0);
        check({tag, "_avail"},      32'({calc_a_available, calc_b_available}), 0);
        check({tag, "_res_valid"},  32'(res_valid), 0);
        check({tag, "_res_gcd"},    32'(res_gcd), 0);
        check({tag, "_res_err"},    32'(res_err), 0);
        check({tag, "_res_cycles"}, 32'(res_cycles), 0);
    endtask

    // Called just after a falling edge. Offers one job, follows it cycle by
    // cycle (cycle 1 = first cycle after the accept edge) and completes the
    // result handshake after 'hold' cycles of res_ready low.
    task automatic run_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int unsigned lat, input logic hang, input int unsigned hold,
                           input logic [7:0] exp_gcd, input logic exp_err,
                           input int unsigned exp_cyc);
        int unsigned rv = 0, a_first = 0, b_first = 0, a_cnt = 0, b_cnt = 0;
        int unsigned clr_hi = 0, overlap = 0, ready_bad = 0, bad = 0;
        logic [7:0]  a_val = 8'd0, b_val = 8'd0;
        logic        disp;
        int unsigned exp_rv;
        disp   = (a != 8'd0) && (b != 8'd0);
        exp_rv = disp ? (CLRC + 3 + exp_cyc) : 1;
        m_lat     = lat;
        m_hang    = hang;
        res_ready = (hold == 0);
        job_a     = a;
        job_b     = b;
        job_valid = 1'b1;
        check({tag, "_job_ready"}, 32'(job_ready), 1);
        @(negedge clk);
        job_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (job_ready) ready_bad++;
            if (calc_a_available) begin
                if (a_first == 0) a_first = k;
                a_cnt++;
                a_val = calc_a;
                if (calc_rst || calc_b_available) overlap++;
            end
            if (calc_b_available) begin
                if (b_first == 0) b_first = k;
                b_cnt++;
                b_val = calc_b;
                if (calc_rst) overlap++;
            end
            if (calc_rst && a_first == 0 && !res_valid) clr_hi++;
            if (res_valid) begin
                rv = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_rv_cycle"},  rv, exp_rv);
        check({tag, "_gcd"},       32'(res_gcd), 32'(exp_gcd));
        check({tag, "_err"},       32'(res_err), 32'(exp_err));
        check({tag, "_cycles"},    32'(res_cycles), exp_cyc);
        check({tag, "_a_strobes"}, a_cnt, disp ? 1 : 0);
        check({tag, "_b_strobes"}, b_cnt, disp ? 1 : 0);
        check({tag, "_overlap"},   overlap, 0);
        check({tag, "_busy_rdy"},  ready_bad, 0);
        if (disp) begin
            check({tag, "_clr_len"}, clr_hi, CLRC);
            check({tag, "_a_cycle"}, a_first, CLRC + 1);
            check({tag, "_b_cycle"}, b_first, CLRC + 2);
            check({tag, "_a_val"},   32'(a_val), 32'(a));
            check({tag, "_b_val"},   32'(b_val), 32'(b));
        end
        for (int i = 0; i < int'(hold); i++) begin
            if (res_gcd !== exp_gcd || res_err !== exp_err || res_cycles !== 16'(exp_cyc)) bad++;
            if (job_ready !== 1'b0 || calc_rst !== 1'b1 || res_valid !== 1'b1) bad++;
            @(negedge clk);
        end
        if (hold != 0) check({tag, "_resp_hold"}, bad, 0);
        res_ready = 1'b1;
        @(negedge clk);
        check({tag, "_post_valid"}, 32'(res_valid), 0);
        check({tag, "_post_ready"}, 32'(job_ready), 1);
    endtask

    // Offers a job that never completes and asserts reset in cycle at_k.
    task automatic abort_job(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input int unsigned at_k, input logic exp_a_av);
        int unsigned rv_seen = 0;
        m_hang    = 1'b1;
        res_ready = 1'b0;
        job_a     = a;
        job_b     = b;
        job_valid = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        for (int k = 1; k < int'(at_k); k++) @(negedge clk);
        check({tag, "_pre_a_av"},  32'(calc_a_available), 32'(exp_a_av));
        check({tag, "_pre_calc_rst"}, 32'(calc_rst), 0);
        rst = 1'b0;
        #1;
        check_reset_values(tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_rel_ready"}, 32'(job_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (res_valid) rv_seen++;
        end
        check({tag, "_no_result"}, rv_seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_release_ready", 32'(job_ready), 1);
        @(negedge clk);

        run_job("j12_18",  8'd12,  8'd18, 4,  1'b0, 0, 8'd6,  1'b0, 4);
        run_job("j0_35",   8'd0,   8'd35, 1,  1'b0, 0, 8'd35, 1'b0, 0);
        run_job("j0_0",    8'd0,   8'd0,  1,  1'b0, 0, 8'd0,  1'b0, 0);
        run_job("j255_1",  8'd255, 8'd1,  7,  1'b0, 0, 8'd1,  1'b0, 7);
        run_job("j48_36",  8'd48,  8'd36, 1,  1'b0, 0, 8'd12, 1'b0, 1);
        run_job("timeout", 8'd100, 8'd75, 1,  1'b1, 0, 8'd0,  1'b1, 16);
        run_job("tie_win", 8'd100, 8'd75, 16, 1'b0, 0, 8'd25, 1'b0, 16);
        run_job("hold5",   8'd9,   8'd6,  3,  1'b0, 5, 8'd3,  1'b0, 3);
        run_job("j35_0",   8'd35,  8'd0,  1,  1'b0, 2, 8'd35, 1'b0, 0);

        abort_job("rst_wait",  8'd77, 8'd11, CLRC + 4, 1'b0);
        run_job("after_w",     8'd20, 8'd8,  2,  1'b0, 0, 8'd4,  1'b0, 2);
        abort_job("rst_loada", 8'd91, 8'd13, CLRC + 1, 1'b1);
        run_job("after_la",    8'd21, 8'd14, 5,  1'b0, 1, 8'd7,  1'b0, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule

// File: doc/gcd_job_driver.md
# gcd_job_driver

Request-side controller for the repeated-subtraction GCD calculator. Accepts operand pairs over a valid/ready job interface, restarts the calculator, presents operand A and then operand B on its one-cycle-per-operand load strobes, and waits for the calculator's `out_ready`. Returns the result, an error flag and the busy-cycle count over a valid/ready result interface. Zero operands are resolved locally because the calculator never terminates on them. A watchdog bounds every dispatched job.

## Interface
- `TIMEOUT_CYCLES`, default 600: maximum WAIT cycles before a job is aborted with an error; must be ≥ 2.
- `CLR_CYCLES`, default 2: cycles that `calc_rst` is held high in CLR before loading; must be ≥ 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `job_valid` in 1: a job is offered.
- `job_ready` out 1: driver accepts a job. High only in IDLE.
- `job_a` in 8: operand A of the offered job.
- `job_b` in 8: operand B of the offered job.
- `calc_rst` out 1: active-high restart to the calculator.
- `calc_a` out 8: operand A to the calculator.
- `calc_b` out 8: operand B to the calculator.
- `calc_a_available` out 1: load strobe for operand A.
- `calc_b_available` out 1: load strobe for operand B.
- `calc_out` in 8: GCD returned by the calculator.
- `calc_out_ready` in 1: calculator result valid (level, sticky until `calc_rst`).
- `res_valid` out 1: result is presented.
- `res_ready` in 1: consumer accepts the result.
- `res_gcd` out 8: GCD; 0 on error.
- `res_err` out 1: job timed out.
- `res_cycles` out 16: WAIT cycles spent on this job; 0 for locally resolved jobs; saturates at 16'hFFFF.

## Operation
- States: IDLE, CLR, LOAD_A, LOAD_B, WAIT, RESP.
- **IDLE:** `job_ready`=1 and `calc_rst`=1.
  - On `job_valid && job_ready`, the operands are latched.
  - If either operand is 0, go to RESP with `res_gcd` = `job_a | job_b` (gcd(x,0)=x, gcd(0,0)=0), `res_err`=0 and `res_cycles`=0. No `calc_*_available` strobe is issued.
  - Otherwise go to CLR.
- **CLR:** `calc_rst`=1 for exactly `CLR_CYCLES` cycles, then go to LOAD_A.
- **LOAD_A:** `calc_rst`=0, `calc_a`=latched A, `calc_a_available`=1 for one cycle. Go to LOAD_B.
- **LOAD_B:** `calc_b`=latched B, `calc_b_available`=1 for one cycle. Clear the wait counter. Go to WAIT.
- **WAIT:** `calc_rst`=0 and the wait counter increments every cycle.
  - `calc_out_ready` sampled 1: capture `calc_out` into `res_gcd`, set `res_err`=0, set `res_cycles`=counter+1, go to RESP.
  - Otherwise, if counter+1 == `TIMEOUT_CYCLES`: `res_gcd`=0, `res_err`=1, `res_cycles`=`TIMEOUT_CYCLES`, go to RESP.
  - If both conditions are true in the same cycle, `calc_out_ready` wins.
- **RESP:** `res_valid`=1 and `calc_rst`=1. The result fields are held stable. On `res_ready`, go to IDLE.
- `calc_a` and `calc_b` hold their last loaded values outside the load states.
- `calc_out` is ignored outside WAIT. A stale `calc_out_ready` is cleared by the `calc_rst` pulse in CLR.
- The wait counter is wide enough for `TIMEOUT_CYCLES`. `res_cycles` saturates and does not wrap.

## Timing
- **Reset (`rst`=0), effective immediately and asynchronously:**
  - state = IDLE;
  - `job_ready`=0 while `rst` is low, and 1 from the first cycle after release;
  - `calc_rst`=1;
  - `calc_a`=`calc_b`=0;
  - both availables 0;
  - `res_valid`=0, `res_gcd`=0, `res_err`=0, `res_cycles`=0.
- Reset in any state drops the in-flight job with no result.
- **Dispatched job:** the accept edge is cycle 0.
  - `calc_rst` high for cycles 1..`CLR_CYCLES`.
  - `calc_a_available` in cycle `CLR_CYCLES`+1.
  - `calc_b_available` in cycle `CLR_CYCLES`+2.
  - First WAIT cycle is `CLR_CYCLES`+3.
  - `res_valid` rises the cycle after `calc_out_ready` is sampled.
- **Zero job:** `res_valid` rises in cycle 1.
- Only one job is in flight. `job_ready`=0 from the accept edge until the cycle after the result handshake.
- The two strobes are never high in the same cycle. Neither strobe is ever high while `calc_rst`=1.

## Test plan
- (12,18) with a behavioural calculator model: strobes in cycles 3 and 4 → `res_gcd`=6, `res_err`=0, `res_cycles` equal to the model's latency.
- (0,35) then (0,0): `res_valid` in cycle 1 with `res_gcd`=35, then 0. `res_cycles`=0, and no availability strobes.
- (255,1) → `res_gcd`=1. Back-to-back jobs with `res_ready` tied high: each job repeats the CLR pulse.
- `TIMEOUT_CYCLES`=16 with a model that never raises `calc_out_ready`: `res_err`=1, `res_gcd`=0, `res_cycles`=16, then the next job completes normally.
- `res_ready` low for 5 cycles in RESP: result fields stable, `job_ready`=0, `calc_rst`=1; the handshake returns the driver to IDLE.
- `rst` asserted mid-WAIT and mid-LOAD_A: outputs take their reset values immediately, no `res_valid`, and a new job after release completes correctly.
